// File: rtl/vga_chroma_scheduler.sv
// Pixel scheduler feeding the VGA controller from a camera FIFO and a background store.
// Optional green-screen keying against the background is enabled by defining CHROMA_KEY_EN.
module vga_chroma_scheduler #(
    parameter int unsigned PIX_W      = 10,
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned KEY_G_MIN  = 600,
    parameter int unsigned KEY_RB_MAX = 300,
    parameter int unsigned FILL       = 0
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iEnable,
    input  logic             iReq,
    input  logic             iV_SYNC,
    input  logic             iCamValid,
    input  logic [PIX_W-1:0] iCamR,
    input  logic [PIX_W-1:0] iCamG,
    input  logic [PIX_W-1:0] iCamB,
    output logic             oCamPop,
    input  logic             iBgValid,
    input  logic [PIX_W-1:0] iBgR,
    input  logic [PIX_W-1:0] iBgG,
    input  logic [PIX_W-1:0] iBgB,
    output logic             oBgPop,
    output logic [PIX_W-1:0] oRed,
    output logic [PIX_W-1:0] oGreen,
    output logic [PIX_W-1:0] oBlue,
    output logic             oUnderflow,
    output logic             oFrameErr,
    output logic             oFrameDone
);

    localparam int unsigned X_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int unsigned Y_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam logic [PIX_W-1:0] FILL_PIX = PIX_W'(FILL);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, FLUSH} state_t;

    state_t           state, stateNext;
    logic             vsPrev;
    logic [X_W-1:0]   xCnt, xNext;
    logic [Y_W-1:0]   yCnt, yNext;
    logic [PIX_W-1:0] rNext, gNext, bNext;
    logic             underflowNext, frameErrNext, frameDoneNext;
    logic             vsFall, lastPix, srcValid, keyEn;
    logic [PIX_W-1:0] selR, selG, selB;

    assign vsFall  = vsPrev & ~iV_SYNC;
    assign lastPix = (xCnt == X_W'(H_ACT - 1)) && (yCnt == Y_W'(V_ACT - 1));

`ifdef CHROMA_KEY_EN
    // Key pixel: strong green with weak red and blue selects the background word.
    logic keyHit;
    assign keyHit   = (iCamG >= PIX_W'(KEY_G_MIN)) && (iCamR <= PIX_W'(KEY_RB_MAX))
                   && (iCamB <= PIX_W'(KEY_RB_MAX));
    assign keyEn    = 1'b1;
    assign srcValid = iCamValid & iBgValid;
    assign selR     = keyHit ? iBgR : iCamR;
    assign selG     = keyHit ? iBgG : iCamG;
    assign selB     = keyHit ? iBgB : iCamB;
`else
    logic unusedBg;
    assign unusedBg = ^{iBgR, iBgG, iBgB, PIX_W'(KEY_G_MIN), PIX_W'(KEY_RB_MAX)};
    assign keyEn    = 1'b0;
    assign srcValid = iCamValid;
    assign selR     = iCamR;
    assign selG     = iCamG;
    assign selB     = iCamB;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            vsPrev     <= 1'b0;
            xCnt       <= '0;
            yCnt       <= '0;
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
            oUnderflow <= 1'b0;
            oFrameErr  <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            state      <= stateNext;
            vsPrev     <= iV_SYNC;
            xCnt       <= xNext;
            yCnt       <= yNext;
            oRed       <= rNext;
            oGreen     <= gNext;
            oBlue      <= bNext;
            oUnderflow <= underflowNext;
            oFrameErr  <= frameErrNext;
            oFrameDone <= frameDoneNext;
        end
    end

    // Pops are combinational so the show-ahead word is consumed in the request cycle.
    always_comb begin
        stateNext     = state;
        xNext         = xCnt;
        yNext         = yCnt;
        rNext         = oRed;
        gNext         = oGreen;
        bNext         = oBlue;
        underflowNext = oUnderflow;
        frameErrNext  = oFrameErr;
        frameDoneNext = 1'b0;
        oCamPop       = 1'b0;
        oBgPop        = 1'b0;
        if (!iEnable) begin
            stateNext = IDLE;
            rNext     = FILL_PIX;
            gNext     = FILL_PIX;
            bNext     = FILL_PIX;
        end else begin
            case (state)
                IDLE: begin
                    rNext         = FILL_PIX;
                    gNext         = FILL_PIX;
                    bNext         = FILL_PIX;
                    stateNext     = SYNC;
                    underflowNext = 1'b0;
                    frameErrNext  = 1'b0;
                end
                SYNC: begin
                    if (vsFall) begin
                        stateNext = ACTIVE;
                        xNext     = '0;
                        yNext     = '0;
                    end
                end
                ACTIVE: begin
                    if (vsFall) begin
                        frameErrNext = 1'b1;
                        xNext        = '0;
                        yNext        = '0;
                    end else if (iReq && srcValid) begin
                        oCamPop = 1'b1;
                        oBgPop  = keyEn;
                        rNext   = selR;
                        gNext   = selG;
                        bNext   = selB;
                        if (lastPix) begin
                            xNext         = '0;
                            yNext         = '0;
                            frameDoneNext = 1'b1;
                            stateNext     = SYNC;
                            underflowNext = 1'b0;
                            frameErrNext  = 1'b0;
                        end else if (xCnt == X_W'(H_ACT - 1)) begin
                            xNext = '0;
                            yNext = yCnt + 1'b1;
                        end else begin
                            xNext = xCnt + 1'b1;
                        end
                    end else if (iReq) begin
                        rNext         = FILL_PIX;
                        gNext         = FILL_PIX;
                        bNext         = FILL_PIX;
                        underflowNext = 1'b1;
                        stateNext     = FLUSH;
                    end
                end
                FLUSH: begin
                    rNext = FILL_PIX;
                    gNext = FILL_PIX;
                    bNext = FILL_PIX;
                    if (vsFall) begin
                        stateNext = ACTIVE;
                        xNext     = '0;
                        yNext     = '0;
                    end else begin
                        oCamPop = iCamValid;
                        oBgPop  = keyEn & iBgValid;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_chroma_scheduler.sv
// Self-checking bench for vga_chroma_scheduler on a reduced 8x4 frame.
// Expected keying results follow the CHROMA_KEY_EN build setting.
module tb_vga_chroma_scheduler;

    localparam int unsigned PIX_W = 10;
    localparam int unsigned H     = 8;
    localparam int unsigned V     = 4;
    localparam int unsigned N     = H * V;
`ifdef CHROMA_KEY_EN
    localparam logic KEYED = 1'b1;
`else
    localparam logic KEYED = 1'b0;
`endif

    typedef struct {
        logic [PIX_W-1:0] cr, cg, cb;
        logic [PIX_W-1:0] br, bg, bb;
        logic [PIX_W-1:0] kr, kg, kb;
    } vec_t;

    typedef struct {
        logic [PIX_W-1:0] r, g, b;
    } pix_t;

    logic iCLK, iRST_N, iEnable, iReq, iV_SYNC, iCamValid, iBgValid;
    logic [PIX_W-1:0] iCamR, iCamG, iCamB, iBgR, iBgG, iBgB;
    logic [PIX_W-1:0] oRed, oGreen, oBlue;
    logic oCamPop, oBgPop, oUnderflow, oFrameErr, oFrameDone;

    pix_t expQ[$];
    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;
    int   camPops = 0;
    int   bgPops  = 0;

    vga_chroma_scheduler #(.PIX_W(PIX_W), .H_ACT(H), .V_ACT(V)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEnable(iEnable), .iReq(iReq), .iV_SYNC(iV_SYNC),
        .iCamValid(iCamValid), .iCamR(iCamR), .iCamG(iCamG), .iCamB(iCamB), .oCamPop(oCamPop),
        .iBgValid(iBgValid), .iBgR(iBgR), .iBgG(iBgG), .iBgB(iBgB), .oBgPop(oBgPop),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oUnderflow(oUnderflow),
        .oFrameErr(oFrameErr), .oFrameDone(oFrameDone)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        if (oCamPop) camPops <= camPops + 1;
        if (oBgPop)  bgPops  <= bgPops + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_out(input logic expDone);
        pix_t p;
        if (expQ.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            p = expQ.pop_front();
            chk("red", 32'(oRed), 32'(p.r));
            chk("green", 32'(oGreen), 32'(p.g));
            chk("blue", 32'(oBlue), 32'(p.b));
        end
        chk("frame_done", 32'(oFrameDone), 32'(expDone));
    endtask

    task automatic serve(input vec_t v, input logic expDone);
        pix_t e;
        iReq = 1'b1; iCamValid = 1'b1; iBgValid = 1'b1;
        iCamR = v.cr; iCamG = v.cg; iCamB = v.cb;
        iBgR  = v.br; iBgG  = v.bg; iBgB  = v.bb;
        #1;
        chk("cam_pop", 32'(oCamPop), 32'd1);
        chk("bg_pop", 32'(oBgPop), 32'(KEYED));
        e.r = KEYED ? v.kr : v.cr;
        e.g = KEYED ? v.kg : v.cg;
        e.b = KEYED ? v.kb : v.cb;
        expQ.push_back(e);
        tick();
        iReq = 1'b0;
        check_out(expDone);
    endtask

    task automatic serve_grey(input logic expDone);
        vec_t v;
        v = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h155, 10'h155, 10'h155, 10'h3FF, 10'h3FF, 10'h3FF};
        serve(v, expDone);
    endtask

    task automatic vs_pulse(input logic withReq);
        iV_SYNC = 1'b0; iReq = withReq; iCamValid = 1'b1; iBgValid = 1'b1;
        #1;
        chk("vs_cam_pop", 32'(oCamPop), 32'd0);
        chk("vs_bg_pop", 32'(oBgPop), 32'd0);
        tick();
        iV_SYNC = 1'b1; iReq = 1'b0;
        tick();
    endtask

    task automatic frame_rest(input int from);
        for (int i = from; i < int'(N); i++) serve_grey(i == int'(N) - 1);
    endtask

    initial begin
        int c0, b0;
        // {cam rgb, bg rgb, keyed-build expected rgb}
        vecs[0] = '{10'd100, 10'd700,  10'd100,  10'd512, 10'd0,  10'd0,  10'd512, 10'd0,   10'd0};
        vecs[1] = '{10'd100, 10'd599,  10'd100,  10'd512, 10'd0,  10'd0,  10'd100, 10'd599, 10'd100};
        vecs[2] = '{10'd300, 10'd600,  10'd300,  10'd1,   10'd2,  10'd3,  10'd1,   10'd2,   10'd3};
        vecs[3] = '{10'd301, 10'd600,  10'd300,  10'd1,   10'd2,  10'd3,  10'd301, 10'd600, 10'd300};
        vecs[4] = '{10'd300, 10'd600,  10'd301,  10'd4,   10'd5,  10'd6,  10'd300, 10'd600, 10'd301};
        vecs[5] = '{10'd0,   10'd1023, 10'd0,    10'd7,   10'd8,  10'd9,  10'd7,   10'd8,   10'd9};
        vecs[6] = '{10'd1023,10'd1023, 10'd1023, 10'd10,  10'd11, 10'd12, 10'd1023,10'd1023,10'd1023};
        vecs[7] = '{10'd0,   10'd0,    10'd0,    10'd13,  10'd14, 10'd15, 10'd0,   10'd0,   10'd0};

        iRST_N = 1'b0; iEnable = 1'b0; iReq = 1'b0; iV_SYNC = 1'b1;
        iCamValid = 1'b1; iBgValid = 1'b1;
        iCamR = '0; iCamG = '0; iCamB = '0; iBgR = '0; iBgG = '0; iBgB = '0;
        tick(); tick();
        chk("rst_rgb", 32'(oRed | oGreen | oBlue), 32'd0);
        chk("rst_flags", 32'({oUnderflow, oFrameErr, oFrameDone}), 32'd0);
        chk("rst_pops", 32'({oCamPop, oBgPop}), 32'd0);
        iRST_N = 1'b1;
        tick();

        // Enable, wait in SYNC for vsync, then one full grey frame
        iEnable = 1'b1;
        tick();
        iReq = 1'b1;
        #1;
        chk("sync_no_pop", 32'({oCamPop, oBgPop}), 32'd0);
        tick();
        iReq = 1'b0;
        vs_pulse(1'b0);
        c0 = camPops; b0 = bgPops;
        frame_rest(0);
        chk("cam_pop_count", 32'(camPops - c0), 32'(N));
        chk("bg_pop_count", 32'(bgPops - b0), KEYED ? 32'(N) : 32'd0);
        tick();
        chk("done_single", 32'(oFrameDone), 32'd0);
        chk("flags_clear", 32'({oUnderflow, oFrameErr}), 32'd0);
        iReq = 1'b1;
        #1;
        chk("post_frame_sync", 32'(oCamPop), 32'd0);
        tick();
        iReq = 1'b0;

        // Keying vectors then rest of frame
        vs_pulse(1'b0);
        for (int i = 0; i < 8; i++) serve(vecs[i], 1'b0);
        frame_rest(8);

        // Underflow mid-frame, flush, resync
        vs_pulse(1'b0);
        for (int i = 0; i < 10; i++) serve_grey(1'b0);
        iReq = 1'b1; iCamValid = 1'b0; iBgValid = 1'b1;
        #1;
        chk("uf_no_pop", 32'({oCamPop, oBgPop}), 32'd0);
        tick();
        iReq = 1'b0;
        chk("uf_rgb", 32'(oRed | oGreen | oBlue), 32'd0);
        chk("uf_flag", 32'(oUnderflow), 32'd1);
        iCamValid = 1'b1; iBgValid = 1'b1;
        #1;
        chk("flush_cam_pop", 32'(oCamPop), 32'd1);
        chk("flush_bg_pop", 32'(oBgPop), 32'(KEYED));
        tick();
        iCamValid = 1'b0;
        #1;
        chk("flush_cam_idle", 32'(oCamPop), 32'd0);
        chk("flush_bg_only", 32'(oBgPop), 32'(KEYED));
        tick();
        iCamValid = 1'b1; iReq = 1'b1;
        tick();
        iReq = 1'b0;
        chk("flush_rgb", 32'(oRed | oGreen | oBlue), 32'd0);
        vs_pulse(1'b0);
        chk("uf_sticky", 32'(oUnderflow), 32'd1);
        frame_rest(0);
        chk("uf_cleared", 32'(oUnderflow), 32'd0);

        // Early vsync with a coincident request
        vs_pulse(1'b0);
        for (int i = 0; i < 5; i++) serve_grey(1'b0);
        vs_pulse(1'b1);
        chk("frame_err", 32'(oFrameErr), 32'd1);
        chk("vs_wins_sb", 32'(expQ.size()), 32'd0);
        frame_rest(0);
        chk("frame_err_clr", 32'(oFrameErr), 32'd0);

        // Missing background word: underflow only when keying is built in
        vs_pulse(1'b0);
        iReq = 1'b1; iCamValid = 1'b1; iBgValid = 1'b0;
        iCamR = 10'h3FF; iCamG = 10'h3FF; iCamB = 10'h3FF;
        #1;
        chk("bgu_cam_pop", 32'(oCamPop), 32'(!KEYED));
        chk("bgu_bg_pop", 32'(oBgPop), 32'd0);
        tick();
        iReq = 1'b0; iBgValid = 1'b1;
        chk("bgu_flag", 32'(oUnderflow), 32'(KEYED));
        chk("bgu_red", 32'(oRed), KEYED ? 32'd0 : 32'h3FF);

        // Disable mid-line, re-enable waits for vsync
        vs_pulse(1'b0);
        for (int i = 0; i < 3; i++) serve_grey(1'b0);
        iEnable = 1'b0; iReq = 1'b1;
        #1;
        chk("dis_no_pop", 32'({oCamPop, oBgPop}), 32'd0);
        tick();
        iReq = 1'b0;
        chk("dis_rgb", 32'(oRed | oGreen | oBlue), 32'd0);
        iEnable = 1'b1;
        tick();
        iReq = 1'b1;
        #1;
        chk("reen_waits", 32'(oCamPop), 32'd0);
        tick();
        iReq = 1'b0;
        vs_pulse(1'b0);
        serve(vecs[0], 1'b0);
        frame_rest(1);
        chk("sb_drained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
